regread_sched: RTL

Sequencer and arbiter for the shared 64-bit 32:1 register-file read port in the branch-on-equal datapath. Two requesters (ALU issue, branch unit) each submit a pair of register indices. The block round-robins between them and drives the port select for two consecutive cycles to fetch both operands. It then returns the operands and their equality flag over a valid/ready response channel.

---
 rtl/regread_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/regread_sched.sv
// Purpose : arbitrates two requesters onto the shared 32:1 register read port and returns both operands plus their equality.
// Latency : 3 cycles from grant cycle to rsp_valid (1 cycle when both indices are XZR with REGREAD_ZERO_REG_EN defined).
// Backpr. : rsp_valid/rsp_ready; no new grant is issued until the current response is accepted.
// Config  : `define REGREAD_ZERO_REG_EN makes index 31 read as constant zero without using the port.
module regread_sched #(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_ra,
    input  logic [AW-1:0] req0_rb,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_ra,
    input  logic [AW-1:0] req1_rb,
    output logic [AW-1:0] port_sel,
    input  logic [DW-1:0] port_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_a,
    output logic [DW-1:0] rsp_b,
    output logic          rsp_eq
);

`ifdef REGREAD_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    localparam logic [AW-1:0] XZR = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        RESP = 2'd3
    } state_t;

    // Request as latched in the grant cycle.
    typedef struct packed {
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          id;
    } req_t;

    state_t        state;
    state_t        state_nxt;
    req_t          lat;
    logic          rr_ptr;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          eq_q;

    logic          gnt0;
    logic          gnt1;
    logic          gnt_any;
    logic [AW-1:0] sel_ra;
    logic [AW-1:0] sel_rb;
    logic          sel_ra_zero;
    logic          sel_rb_zero;
    logic          lat_rb_zero;

    // Grant decision: only in IDLE; a lone requester wins, otherwise the pointer picks.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        gnt_any     = gnt0 | gnt1;
        sel_ra      = gnt1 ? req1_ra : req0_ra;
        sel_rb      = gnt1 ? req1_rb : req0_rb;
        sel_ra_zero = ZERO_EN && (sel_ra == XZR);
        sel_rb_zero = ZERO_EN && (sel_rb == XZR);
        lat_rb_zero = ZERO_EN && (lat.rb == XZR);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: XZR reads skip their port cycle when zero-register support is built in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    if (!sel_ra_zero) begin
                        state_nxt = RD_A;
                    end else if (!sel_rb_zero) begin
                        state_nxt = RD_B;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RD_A:    state_nxt = lat_rb_zero ? RESP : RD_B;
            RD_B:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: port select from latched indices, response straight from registers.
    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        port_sel   = '0;
        case (state)
            RD_A:    port_sel = lat.ra;
            RD_B:    port_sel = lat.rb;
            default: port_sel = '0;
        endcase
        rsp_valid = (state == RESP);
        rsp_id    = lat.id;
        rsp_a     = a_q;
        rsp_b     = b_q;
        rsp_eq    = eq_q;
    end

    // Datapath: latch request on grant, capture operands, compare the captured data, rotate pointer on handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat    <= '0;
            rr_ptr <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            eq_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        lat.ra <= sel_ra;
                        lat.rb <= sel_rb;
                        lat.id <= gnt1;
                        if (sel_ra_zero) begin
                            a_q <= '0;
                        end
                        if (sel_ra_zero && sel_rb_zero) begin
                            b_q  <= '0;
                            eq_q <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    a_q <= port_data;
                    if (lat_rb_zero) begin
                        b_q  <= '0;
                        eq_q <= (port_data == '0);
                    end
                end
                RD_B: begin
                    b_q  <= port_data;
                    eq_q <= (a_q == port_data);
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= ~lat.id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
